clint_trap_ctrl: RTL and testbench

//  Core-local trap sequencer that drives the CSR file's clint write port.
//  - Detects ecall/ebreak/mret in EX and level-sensitive timer/external interrupts.
//  - Stalls the pipeline and writes mepc, mstatus and mcause one CSR per cycle.
//  - Redirects the PC to the trap vector, or to mepc on mret.

---
 rtl/clint_trap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_clint_trap_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: core-local trap sequencer.
// Detects ecall/ebreak/mret in EX and level-sensitive timer/external interrupts.
// On a trap it stalls the pipeline and writes mepc, mstatus and mcause one per
// cycle, then redirects the PC to the trap vector. On mret it restores mstatus
// and the privilege mode, then redirects the PC to mepc.
module clint_trap_ctrl #(
  parameter bit VECTORED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_csr_we_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [1:0]  privilege_i,
  output logic        clint_we_o,
  output logic [31:0] clint_waddr_o,
  output logic [31:0] clint_wdata_o,
  output logic        priv_we_o,
  output logic [1:0]  priv_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS  = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC     = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE   = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_MEPC,
    S_T_MSTATUS,
    S_T_MCAUSE,
    S_T_ASSERT,
    S_M_MSTATUS,
    S_M_ASSERT
  } state_t;

  state_t      state_q;
  logic [31:0] cause_q;
  logic [31:0] mstatus_q;
  logic [1:0]  priv_q;
  logic        irq_q;

  logic        is_sync;
  logic        is_mret;
  logic        is_irq;
  logic        event_now;
  logic [31:0] cause_d;
  logic [31:0] epc_d;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] trap_vec;

  assign is_sync   = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  // An interrupt yields to a CSR write in EX so that write lands first.
  assign is_irq    = (timer_irq_i | ext_irq_i) & csr_mstatus_i[3] & ~ex_csr_we_i;
  assign event_now = (state_q == S_IDLE) & (is_sync | is_mret | is_irq);

  // The stall must cover the event cycle itself, so it cannot be registered.
  assign hold_o = (state_q != S_IDLE) | event_now;

  // Cause code and return address of the event sampled in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    cause_d = CAUSE_EXT;
    epc_d   = inst_addr_i;
    if (inst_i == INST_ECALL)       cause_d = CAUSE_ECALL;
    else if (inst_i == INST_EBREAK) cause_d = CAUSE_EBREAK;
    else if (timer_irq_i)           cause_d = CAUSE_TIMER;
    // Interrupts resume after the EX instruction, which has already completed.
    if (!is_sync) epc_d = jump_flag_i ? jump_addr_i : inst_addr_i + 32'd4;
  end

  // mstatus images for trap entry (from the snapshot) and mret (live value).
  always_comb begin
    trap_mstatus        = mstatus_q;
    trap_mstatus[7]     = mstatus_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = priv_q;
    mret_mstatus        = csr_mstatus_i;
    mret_mstatus[3]     = csr_mstatus_i[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b00;
  end

  // Trap target: aligned mtvec base, offset by 4*cause for vectored interrupts.
  always_comb begin
    trap_vec = {csr_mtvec_i[31:2], 2'b00};
    if (VECTORED && irq_q) trap_vec = trap_vec + {25'd0, cause_q[4:0], 2'b00};
  end

  // Sequencer: each state's outputs are registered on entry to that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cause_q       <= '0;
      mstatus_q     <= '0;
      priv_q        <= '0;
      irq_q         <= 1'b0;
      clint_we_o    <= 1'b0;
      clint_waddr_o <= '0;
      clint_wdata_o <= '0;
      priv_we_o     <= 1'b0;
      priv_o        <= '0;
      int_assert_o  <= 1'b0;
      int_addr_o    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from the same pre-edge values.
      clint_we_o    <= 1'b0;
      clint_waddr_o <= '0;
      clint_wdata_o <= '0;
      priv_we_o     <= 1'b0;
      priv_o        <= '0;
      int_assert_o  <= 1'b0;
      int_addr_o    <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (is_sync || (!is_mret && is_irq)) begin
            cause_q       <= cause_d;
            mstatus_q     <= csr_mstatus_i;
            priv_q        <= privilege_i;
            irq_q         <= !is_sync;
            clint_we_o    <= 1'b1;
            clint_waddr_o <= CSR_MEPC;
            clint_wdata_o <= epc_d;
            state_q       <= S_T_MEPC;
          end else if (is_mret) begin
            clint_we_o    <= 1'b1;
            clint_waddr_o <= CSR_MSTATUS;
            clint_wdata_o <= mret_mstatus;
            priv_we_o     <= 1'b1;
            priv_o        <= csr_mstatus_i[12:11];
            state_q       <= S_M_MSTATUS;
          end
        end
        S_T_MEPC: begin
          clint_we_o    <= 1'b1;
          clint_waddr_o <= CSR_MSTATUS;
          clint_wdata_o <= trap_mstatus;
          state_q       <= S_T_MSTATUS;
        end
        S_T_MSTATUS: begin
          clint_we_o    <= 1'b1;
          clint_waddr_o <= CSR_MCAUSE;
          clint_wdata_o <= cause_q;
          priv_we_o     <= 1'b1;
          priv_o        <= 2'b11;
          state_q       <= S_T_MCAUSE;
        end
        S_T_MCAUSE: begin
          int_assert_o <= 1'b1;
          int_addr_o   <= trap_vec;
          state_q      <= S_T_ASSERT;
        end
        S_M_MSTATUS: begin
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
          state_q      <= S_M_ASSERT;
        end
        S_T_ASSERT, S_M_ASSERT: state_q <= S_IDLE;
        default:                state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the trap sequences.
module tb_clint_trap_ctrl;

  localparam bit          VEC    = 1'b1;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SENT   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, ex_csr_we_i, timer_irq_i, ext_irq_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic [1:0]  privilege_i;
  logic        clint_we_o, priv_we_o, hold_o, int_assert_o;
  logic [31:0] clint_waddr_o, clint_wdata_o, int_addr_o;
  logic [1:0]  priv_o;

  clint_trap_ctrl #(.VECTORED(VEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_csr_we_i(ex_csr_we_i), .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .privilege_i(privilege_i),
    .clint_we_o(clint_we_o), .clint_waddr_o(clint_waddr_o),
    .clint_wdata_o(clint_wdata_o), .priv_we_o(priv_we_o), .priv_o(priv_o),
    .hold_o(hold_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  // One expected output cycle.
  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        pwe;
    logic [1:0]  priv;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Staged stimulus, applied at the next falling edge.
  logic [31:0] s_inst, s_addr, s_jaddr, s_mtvec, s_mepc, s_mstatus;
  logic        s_jump, s_exwe, s_timer, s_ext;
  logic [1:0]  s_priv;

  // Observations from the DUT used by directed scenario checks.
  logic [31:0] last_mepc, last_ms, last_mcause, last_iaddr;
  logic [1:0]  last_priv;
  int          last_icyc, n_wr, n_assert;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic pwe, input logic [1:0] pv,
                              input logic ia, input logic [31:0] iaddr);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd; e.pwe = pwe; e.priv = pv;
    e.ia = ia; e.iaddr = iaddr;
    return e;
  endfunction

  task automatic set_idle();
    s_inst = NOP; s_addr = '0; s_jaddr = '0; s_jump = 0; s_exwe = 0;
    s_timer = 0; s_ext = 0; s_mstatus = '0; s_priv = 2'b00;
  endtask

  task automatic clear_obs();
    last_mepc = SENT; last_ms = SENT; last_mcause = SENT; last_iaddr = SENT;
    last_priv = 2'b00; last_icyc = -1; n_wr = 0; n_assert = 0;
  endtask

  task automatic apply();
    inst_i = s_inst; inst_addr_i = s_addr; jump_flag_i = s_jump; jump_addr_i = s_jaddr;
    ex_csr_we_i = s_exwe; timer_irq_i = s_timer; ext_irq_i = s_ext;
    csr_mtvec_i = s_mtvec; csr_mepc_i = s_mepc; csr_mstatus_i = s_mstatus;
    privilege_i = s_priv;
  endtask

  // One clock cycle: apply stimulus, compare DUT against the model, then let
  // the model react to any event sampled this cycle.
  task automatic step();
    exp_t        e;
    logic        busy, sync, mret, irq;
    logic [31:0] cause, epc, ms, vec;
    @(negedge clk);
    apply();
    #1;
    cyc++;
    busy = (exp_q.size() != 0);
    e = '0;
    if (busy) e = exp_q.pop_front();
    sync = (s_inst == ECALL) || (s_inst == EBREAK);
    mret = (s_inst == MRET);
    irq  = (s_timer || s_ext) && s_mstatus[3] && !s_exwe;

    check("we",         32'(clint_we_o),   32'(e.we));
    check("waddr",      clint_waddr_o,     e.waddr);
    check("wdata",      clint_wdata_o,     e.wdata);
    check("priv_we",    32'(priv_we_o),    32'(e.pwe));
    check("priv",       32'(priv_o),       32'(e.priv));
    check("int_assert", 32'(int_assert_o), 32'(e.ia));
    check("int_addr",   int_addr_o,        e.iaddr);
    check("hold",       32'(hold_o),       32'(busy || sync || mret || irq));

    if (clint_we_o) begin
      n_wr++;
      if (clint_waddr_o == 32'h341) last_mepc = clint_wdata_o;
      if (clint_waddr_o == 32'h300) last_ms = clint_wdata_o;
      if (clint_waddr_o == 32'h342) last_mcause = clint_wdata_o;
    end
    if (priv_we_o) last_priv = priv_o;
    if (int_assert_o) begin
      last_iaddr = int_addr_o; last_icyc = cyc; n_assert++;
    end

    if (!busy) begin
      ms = s_mstatus;
      if (sync || (!mret && irq)) begin
        if (s_inst == ECALL)       cause = 32'd11;
        else if (s_inst == EBREAK) cause = 32'd3;
        else if (s_timer)          cause = 32'h8000_0007;
        else                       cause = 32'h8000_000B;
        epc = sync ? s_addr : (s_jump ? s_jaddr : s_addr + 32'd4);
        ms[7] = s_mstatus[3]; ms[3] = 1'b0; ms[12:11] = s_priv;
        vec = {s_mtvec[31:2], 2'b00};
        if (VEC && !sync) vec = vec + 32'd4 * (cause & 32'h1F);
        exp_q.push_back(mk(1, 32'h341, epc, 0, 2'b00, 0, '0));
        exp_q.push_back(mk(1, 32'h300, ms, 0, 2'b00, 0, '0));
        exp_q.push_back(mk(1, 32'h342, cause, 1, 2'b11, 0, '0));
        exp_q.push_back(mk(0, '0, '0, 0, 2'b00, 1, vec));
      end else if (mret) begin
        ms[3] = s_mstatus[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
        exp_q.push_back(mk(1, 32'h300, ms, 1, s_mstatus[12:11], 0, '0));
        exp_q.push_back(mk(0, '0, '0, 0, 2'b00, 1, s_mepc));
      end
    end
  endtask

  initial begin
    int ev;
    int r;
    set_idle();
    s_mtvec = 32'h200; s_mepc = '0;
    apply();
    clear_obs();

    // Reset state.
    #2;
    check("rst_we", 32'(clint_we_o), 0);
    check("rst_hold", 32'(hold_o), 0);
    check("rst_assert", 32'(int_assert_o), 0);
    check("rst_addr", int_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ecall from M-mode.
    clear_obs();
    s_mtvec = 32'h200; s_mstatus = 32'h8; s_priv = 2'b11; s_inst = ECALL; s_addr = 32'h100;
    step(); ev = cyc;
    set_idle();
    repeat (4) step();
    check("ecall_mepc", last_mepc, 32'h100);
    check("ecall_mstatus", last_ms, 32'h1880);
    check("ecall_mcause", last_mcause, 32'd11);
    check("ecall_vec", last_iaddr, 32'h200);
    check("ecall_lat", 32'(last_icyc - ev), 32'd4);

    // mret restoring MIE.
    clear_obs();
    s_mstatus = 32'h1880; s_mepc = 32'h104; s_inst = MRET;
    step(); ev = cyc;
    set_idle();
    repeat (2) step();
    check("mret_mstatus", last_ms, 32'h88);
    check("mret_priv", 32'(last_priv), 32'd3);
    check("mret_addr", last_iaddr, 32'h104);
    check("mret_lat", 32'(last_icyc - ev), 32'd2);

    // Vectored timer interrupt on a taken jump.
    clear_obs();
    s_mtvec = 32'h201; s_mstatus = 32'h8; s_timer = 1; s_jump = 1;
    s_jaddr = 32'h400; s_addr = 32'h500;
    step();
    set_idle();
    repeat (4) step();
    check("tirq_mepc", last_mepc, 32'h400);
    check("tirq_mcause", last_mcause, 32'h8000_0007);
    check("tirq_vec", last_iaddr, 32'h21C);

    // Masked interrupt: nothing happens.
    clear_obs();
    s_timer = 1; s_ext = 1; s_mstatus = 32'h0;
    repeat (3) step();
    check("masked_writes", 32'(n_wr), 0);
    set_idle();

    // Interrupt deferred by one EX CSR write.
    clear_obs();
    s_ext = 1; s_mstatus = 32'h8; s_exwe = 1; s_addr = 32'h40;
    step(); ev = cyc;
    s_exwe = 0;
    step();
    set_idle();
    repeat (4) step();
    check("defer_lat", 32'(last_icyc - ev), 32'd5);
    check("defer_mcause", last_mcause, 32'h8000_000B);
    check("defer_vec", last_iaddr, 32'h200 + 32'h2C);

    // ebreak beats a simultaneous external interrupt.
    clear_obs();
    s_inst = EBREAK; s_ext = 1; s_mstatus = 32'h8; s_addr = 32'h80;
    step();
    set_idle();
    repeat (4) step();
    check("ebrk_mcause", last_mcause, 32'd3);
    check("ebrk_mepc", last_mepc, 32'h80);
    check("ebrk_vec", last_iaddr, 32'h200);

    // Reset during the mstatus write aborts the sequence.
    clear_obs();
    s_inst = ECALL; s_mstatus = 32'h8; s_addr = 32'h300;
    step();
    set_idle();
    step();
    step();
    check("pre_rst_we", 32'(clint_we_o), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(clint_we_o), 0);
    check("arst_wdata", clint_wdata_o, 0);
    check("arst_hold", 32'(hold_o), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    check("arst_no_mcause", last_mcause, SENT);
    check("arst_no_assert", 32'(n_assert), 0);

    // Return-address wrap for an interrupt at the top of memory.
    clear_obs();
    s_timer = 1; s_mstatus = 32'h8; s_addr = 32'hFFFF_FFFC;
    step();
    set_idle();
    repeat (4) step();
    check("wrap_mepc", last_mepc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      s_inst  = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET : $urandom;
      s_exwe  = (r <= 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      s_timer = ($urandom_range(0, 7) == 0);
      s_ext   = ($urandom_range(0, 7) == 0);
      s_mstatus = $urandom;
      s_priv  = 2'($urandom_range(0, 3));
      s_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      s_jump  = $urandom_range(0, 1) == 1;
      s_jaddr = $urandom & 32'hFFFF_FFFC;
      if (exp_q.size() == 0) begin
        s_mtvec = $urandom;
        s_mepc  = $urandom;
      end
      step();
    end
    set_idle();
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
